// File: rtl/bcd_7seg_scanner.sv
// -----------------------------------------------------------------------------
// bcd_7seg_scanner
//
// Display stage that sits after the BCD digit counters. On a load strobe it takes
// a snapshot of a packed vector of BCD digits and their decimal-point requests.
// It then time-multiplexes that snapshot onto a common-anode 7-segment display.
//
// Each digit gets one scan slot of SCAN_DIV clock cycles. The scan order is
// 0..NUM_DIGITS-1, where digit 0 is the rightmost, least significant digit.
// Codes 10..15 are shown as a dash.
//
// Every output comes straight from a flop, so the display never glitches.
//
// Optional feature (compile-time macro BCD_SCAN_LZB_EN):
//   When defined, leading-zero blanking is built in. Digit k (k >= 1) shows
//   seg = 7'h7F when it and every more-significant snapshot digit are 0.
//   Digit 0 is never blanked.
//   When undefined, every digit is decoded.
//
// Parameters:
//   NUM_DIGITS  digits scanned, 1..8
//   SCAN_DIV    clk cycles per digit slot, >= 2
//
// Ports:
//   clk     in   clock, posedge
//   rst     in   synchronous active-high reset (overrides load)
//   bcd_in  in   [4*NUM_DIGITS-1:0] packed digits, digit k = bcd_in[4k+3:4k]
//   dp_in   in   [NUM_DIGITS-1:0] decimal-point request per digit, 1 = lit
//   load    in   capture bcd_in/dp_in into the snapshot this cycle
//   an      out  [NUM_DIGITS-1:0] digit enables, active-low, one-hot-low
//   seg     out  [6:0] {g,f,e,d,c,b,a}, active-low
//   dp      out  decimal point, active-low
// -----------------------------------------------------------------------------
module bcd_7seg_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

   generate
      if (SCAN_DIV < 2) begin : g_bad_scan_div
         $error("bcd_7seg_scanner: SCAN_DIV must be >= 2");
      end
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
         $error("bcd_7seg_scanner: NUM_DIGITS must be 1..8");
      end
   endgenerate

   // Active-low decode: 0-9 are the usual glyphs, 10-15 light only g (dash).
   function automatic logic [6:0] decode7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   logic [4*NUM_DIGITS-1:0] snap_q,    snap_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [PW-1:0]           presc_q,   presc_d;
   logic [IW-1:0]           idx_q,     idx_d;
   logic [NUM_DIGITS-1:0]   an_q,      an_d;
   logic [6:0]              seg_q,     seg_d;
   logic                    dp_q,      dp_d;

   logic                    tick;
   logic [3:0]              cur_digit;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   blank_vec;

   // Leading-zero blanking flags, one per digit. They are taken from the
   // snapshot, so they are stable for the whole frame.
`ifdef BCD_SCAN_LZB_EN
   always_comb begin
      logic zero_run;
      zero_run  = 1'b1;
      blank_vec = '0;
      // Walk from the most significant digit down. Stop before digit 0 so a
      // value of zero still shows one "0".
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run     = zero_run & (snap_q[4*k +: 4] == 4'd0);
         blank_vec[k] = zero_run;
      end
   end
`else
   always_comb begin
      blank_vec = '0;
   end
`endif

   always_comb begin
      // Snapshot holds unless loaded, so bcd_in may change freely.
      snap_d    = load ? bcd_in : snap_q;
      snap_dp_d = load ? dp_in  : snap_dp_q;

      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + PW'(1);

      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end

      // Select the current digit from the pre-edge idx and snapshot. This gives
      // the outputs exactly one cycle of latency.
      cur_digit = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      an_d      = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_digit = snap_q[4*k +: 4];
            cur_dp    = snap_dp_q[k];
            cur_blank = blank_vec[k];
            an_d[k]   = 1'b0;
         end
      end

      seg_d = cur_blank ? 7'h7F : decode7(cur_digit);
      dp_d  = ~cur_dp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q    <= '0;
         snap_dp_q <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
         an_q      <= '1;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
      end else begin
         snap_q    <= snap_d;
         snap_dp_q <= snap_dp_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_7seg_scanner
//
// Bench for bcd_7seg_scanner with NUM_DIGITS=4 and SCAN_DIV=4.
//
// Each record in the vector table holds a load value and the per-digit seg/dp
// that the display should show for it. The expected seg values are written out
// from the decode table.
//
// Before every clock edge the bench pushes the expected {an, seg, dp} for that
// edge onto exp_q. Just after the edge it pops that entry and compares it with
// the DUT outputs.
//
// The scan position is tracked as the number of edges since reset release:
// slot = (edges / SCAN_DIV) % NUM_DIGITS.
// -----------------------------------------------------------------------------
module tb_bcd_7seg_scanner;
   localparam int ND = 4;
   localparam int SD = 4;

`ifdef BCD_SCAN_LZB_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif
   localparam logic [3:0][6:0] ZSEG = {LZ, LZ, LZ, 7'h40};

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] bcd_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   always #5 clk = ~clk;

   bcd_7seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
      .clk    (clk),
      .rst    (rst),
      .bcd_in (bcd_in),
      .dp_in  (dp_in),
      .load   (load),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0]     bcd;
      logic [3:0]      dpin;
      logic [3:0][6:0] seg;   // {d3,d2,d1,d0}
      logic [3:0]      dpo;   // expected active-low dp per digit
   } vec_t;

   vec_t vecs[7];

   // ---------------- scoreboard / model state ----------------
   logic [11:0]     exp_q[$];
   logic [3:0][6:0] m_seg = ZSEG;
   logic [3:0]      m_dpo = 4'hF;
   int              e_cnt = 0;
   int              total = 0;
   int              bad   = 0;

   // One clock: drive the inputs, push the expected output for this edge,
   // advance the model, then compare just after the edge.
   task automatic step(input string tag, input logic r, input logic ld,
                       input logic [15:0] b, input logic [3:0] d,
                       input logic [3:0][6:0] nseg, input logic [3:0] ndpo);
      int          dg;
      logic [3:0]  oh;
      logic [11:0] exp_v;
      logic [11:0] got_v;
      rst    = r;
      load   = ld;
      bcd_in = b;
      dp_in  = d;
      if (r) begin
         exp_q.push_back({4'hF, 7'h7F, 1'b1});
         m_seg = ZSEG;
         m_dpo = 4'hF;
         e_cnt = 0;
      end else begin
         dg = (e_cnt / SD) % ND;
         oh = 4'b0001 << dg;
         exp_q.push_back({~oh, m_seg[dg], m_dpo[dg]});
         if (ld) begin
            m_seg = nseg;
            m_dpo = ndpo;
         end
         e_cnt++;
      end
      @(posedge clk);
      #1;
      got_v = {an, seg, dp};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, got an=%h seg=%h dp=%b", tag, an, seg, dp);
      end else begin
         exp_v = exp_q.pop_front();
         if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s (edge %0d): got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     tag, e_cnt, got_v[11:8], got_v[7:1], got_v[0],
                     exp_v[11:8], exp_v[7:1], exp_v[0]);
         end
      end
   endtask

   // Idle cycles with random bcd_in/dp_in and load low: the snapshot must hold.
   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step(tag, 1'b0, 1'b0, 16'($urandom_range(0, 65535)),
              4'($urandom_range(0, 15)), m_seg, m_dpo);
      end
   endtask

   task automatic load_vec(input string tag, input int i);
      step(tag, 1'b0, 1'b1, vecs[i].bcd, vecs[i].dpin, vecs[i].seg, vecs[i].dpo);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0100, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011};
      vecs[1] = '{16'h00A9, 4'b0000, {LZ,    LZ,    7'h3F, 7'h10}, 4'b1111};
      vecs[2] = '{16'h0050, 4'b1001, {LZ,    LZ,    7'h12, 7'h40}, 4'b0110};
      vecs[3] = '{16'h8765, 4'b1111, {7'h00, 7'h78, 7'h02, 7'h12}, 4'b0000};
      vecs[4] = '{16'hFEDC, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};
      vecs[5] = '{16'h0000, 4'b0000, {LZ,    LZ,    LZ,    7'h40}, 4'b1111};
      vecs[6] = '{16'h0900, 4'b0010, {LZ,    7'h10, 7'h40, 7'h40}, 4'b1101};

      // Reset for 3 cycles; the last one also has load high and must not
      // capture anything.
      step("reset_dark", 1'b1, 1'b0, 16'h0, 4'h0, ZSEG, 4'hF);
      step("reset_dark", 1'b1, 1'b0, 16'h0, 4'h0, ZSEG, 4'hF);
      step("reset_over_load", 1'b1, 1'b1, 16'h1234, 4'hF, ZSEG, 4'hF);
      run("post_reset_frame", 16);

      // Table: load each vector, then watch a full frame and one more slot.
      for (int i = 0; i < 7; i++) begin
         load_vec($sformatf("vec%0d_load", i), i);
         run($sformatf("vec%0d_scan", i), 20);
      end

      // Hold check: rec0 is loaded, then bcd_in changes freely for two frames.
      load_vec("hold_load", 0);
      run("hold_scan", 32);

      // Load on the same edge as the tick: the next slot must show the new
      // digit from the new snapshot.
      while ((e_cnt % SD) != SD - 1) run("align_tick", 1);
      load_vec("load_on_tick", 3);
      run("after_load_on_tick", 12);

      // Reset in the middle of the scan while idx = 2.
      load_vec("pre_midreset_load", 0);
      while (((e_cnt / SD) % ND) != 2) run("align_idx2", 1);
      run("in_idx2", 1);
      step("midscan_reset", 1'b1, 1'b0, 16'h5555, 4'h0, ZSEG, 4'hF);
      run("after_midscan_reset", 18);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound, total=%0d", total);
      $fatal(1, "timeout");
   end

endmodule
